// File: rtl/fp_add_arbiter.sv
// Round-robin front end that shares one pipelined FP adder among N_REQ requesters.
// Each op is tagged with its requester index and the result is routed back through a per-requester response register.
module fp_add_arbiter #(
    parameter int N_REQ      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_vld_i,
    input  logic [N_REQ*32-1:0]  req_a_i,
    input  logic [N_REQ*32-1:0]  req_b_i,
    output logic [N_REQ-1:0]     req_rdy_o,
    output logic [N_REQ-1:0]     rsp_vld_o,
    output logic [N_REQ*32-1:0]  rsp_result_o,
    output logic [N_REQ*2-1:0]   rsp_state_o,
    input  logic [N_REQ-1:0]     rsp_rdy_i,
    output logic [31:0]          add_a_o,
    output logic [31:0]          add_b_o,
    output logic                 add_arg_vld_o,
    input  logic [31:0]          add_result_i,
    input  logic [1:0]           add_state_i,
    input  logic                 add_res_vld_i,
    output logic                 err_o
);

    localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [N_REQ-1:0]    busy_q, busy_d;
    logic [N_REQ-1:0]    rel_q, rel_d;
    logic [TAG_W-1:0]    ptr_q, ptr_d;
    logic [TAG_W-1:0]    tag_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0]    rsp_vld_q, rsp_vld_d;
    logic [N_REQ*32-1:0] rsp_result_q;
    logic [N_REQ*2-1:0]  rsp_state_q;
    logic [31:0]         add_a_q, add_b_q;
    logic                add_arg_vld_q;
    logic                err_q;

    logic [N_REQ-1:0]    elig;
    logic [N_REQ-1:0]    grant_oh;
    logic [TAG_W-1:0]    gnt_idx;
    logic                gnt_found;
    logic                gnt_vld;
    logic                fifo_full, fifo_empty;
    logic                push, pop;
    logic [TAG_W-1:0]    pop_tag;
    int                  scan_idx;

    assign elig       = req_vld_i & ~busy_q;
    assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);

    // Search starts at ptr_q and wraps, so the most recent winner has lowest priority.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = (int'(ptr_q) + k) % N_REQ;
            if (!gnt_found && elig[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = TAG_W'(scan_idx);
            end
        end
    end

    // Gated by rst_i so req_rdy_o is 0 throughout reset, not just after it.
    assign gnt_vld = gnt_found & ~fifo_full & ~rst_i;

    always_comb begin
        grant_oh = '0;
        if (gnt_vld) grant_oh[gnt_idx] = 1'b1;
    end

    assign push    = gnt_vld;
    assign pop     = add_res_vld_i & ~fifo_empty;
    assign pop_tag = tag_mem[rd_ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) ptr_d = (gnt_idx == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
    end

    // busy drops one cycle after the response handshake, so a re-grant lands two cycles after it.
    assign rel_d  = rsp_vld_q & rsp_rdy_i;
    assign busy_d = (busy_q & ~rel_q) | grant_oh;

    always_comb begin
        rsp_vld_d = rsp_vld_q & ~rsp_rdy_i;
        if (pop) rsp_vld_d[pop_tag] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push) tag_mem[wr_ptr_q] <= gnt_idx;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q        <= '0;
            rel_q         <= '0;
            ptr_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
            rsp_vld_q     <= '0;
            rsp_result_q  <= '0;
            rsp_state_q   <= '0;
            add_a_q       <= '0;
            add_b_q       <= '0;
            add_arg_vld_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            rel_q         <= rel_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            rsp_vld_q     <= rsp_vld_d;
            add_arg_vld_q <= gnt_vld;
            if (gnt_vld) begin
                add_a_q <= req_a_i[32*gnt_idx +: 32];
                add_b_q <= req_b_i[32*gnt_idx +: 32];
            end
            if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
                rsp_result_q[32*pop_tag +: 32] <= add_result_i;
                rsp_state_q[2*pop_tag +: 2]    <= add_state_i;
            end
            // A result with no tag outstanding can only be stale or spurious.
            if (add_res_vld_i && fifo_empty) err_q <= 1'b1;
        end
    end

    assign req_rdy_o     = grant_oh;
    assign rsp_vld_o     = rsp_vld_q;
    assign rsp_result_o  = rsp_result_q;
    assign rsp_state_o   = rsp_state_q;
    assign add_a_o       = add_a_q;
    assign add_b_o       = add_b_q;
    assign add_arg_vld_o = add_arg_vld_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a small behavioural adder stand-in.
// The stand-in returns results in issue order and can be stalled or made to inject a spurious result.
module tb_fp_add_arbiter;

    localparam int N = 4;
    localparam int D = 2;
    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_NAN = 2'd1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_vld = '0;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic [N-1:0]    req_rdy;
    logic [N-1:0]    rsp_vld;
    logic [N*32-1:0] rsp_result;
    logic [N*2-1:0]  rsp_state;
    logic [N-1:0]    rsp_rdy = '0;
    logic [31:0]     add_a, add_b;
    logic            add_arg_vld;
    logic [31:0]     add_result = '0;
    logic [1:0]      add_state = '0;
    logic            add_res_vld = 1'b0;
    logic            err;

    logic            stall = 1'b0;
    logic            inject = 1'b0;
    logic [33:0]     pend[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_add_arbiter #(.N_REQ(N), .FIFO_DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_vld_i(req_vld), .req_a_i(req_a), .req_b_i(req_b), .req_rdy_o(req_rdy),
        .rsp_vld_o(rsp_vld), .rsp_result_o(rsp_result), .rsp_state_o(rsp_state), .rsp_rdy_i(rsp_rdy),
        .add_a_o(add_a), .add_b_o(add_b), .add_arg_vld_o(add_arg_vld),
        .add_result_i(add_result), .add_state_i(add_state), .add_res_vld_i(add_res_vld),
        .err_o(err)
    );

    // Stand-in adder: known pairs give real IEEE results, NaN input gives NAN, otherwise integer sum.
    function automatic logic [33:0] model_add(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return {32'h4040_0000, ST_OK};
        if (a[30:23] == 8'hFF && a[22:0] != 23'd0)     return {32'h7FC0_0000, ST_NAN};
        return {a + b, ST_OK};
    endfunction

    always @(negedge clk) begin
        logic [33:0] r;
        add_res_vld = 1'b0;
        if (add_arg_vld) pend.push_back(model_add(add_a, add_b));
        if (inject) begin
            add_res_vld = 1'b1;
            add_result  = 32'hDEAD_BEEF;
            add_state   = ST_OK;
        end else if (!stall && pend.size() != 0) begin
            r = pend.pop_front();
            add_res_vld = 1'b1;
            add_result  = r[33:2];
            add_state   = r[1:0];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] op_a(input int i);
        return 32'h10 + i;
    endfunction

    function automatic logic [31:0] op_b(input int i);
        return 32'h100 << i;
    endfunction

    initial begin
        logic [3:0] exp_oh;
        logic [3:0] bp_rdy [9];
        bp_rdy = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001};

        // reset state
        tick(); tick();
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_arg_vld", add_arg_vld, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        // single op on requester 0
        tick();
        req_a[31:0] = 32'h3F80_0000;
        req_b[31:0] = 32'h4000_0000;
        req_vld = 4'b0001;
        #1;
        chk("t1_grant", req_rdy, 4'b0001);
        tick();
        req_vld = '0;
        chk("t1_arg_vld", add_arg_vld, 1);
        chk("t1_add_a", add_a, 32'h3F80_0000);
        chk("t1_add_b", add_b, 32'h4000_0000);
        chk("t1_no_rsp_yet", rsp_vld, 0);
        tick();
        chk("t1_arg_vld_drop", add_arg_vld, 0);
        chk("t1_rsp_vld", rsp_vld, 4'b0001);
        chk("t1_result", rsp_result[31:0], 32'h4040_0000);
        chk("t1_state", rsp_state[1:0], ST_OK);
        tick();
        chk("t1_rsp_hold", rsp_vld, 4'b0001);
        req_vld = 4'b0001;
        #1;
        chk("t1_busy_block", req_rdy, 0);
        req_vld = '0;
        rsp_rdy = 4'b0001;
        tick();
        chk("t1_rsp_clear", rsp_vld, 0);
        rsp_rdy = '0;
        tick();

        // all four requesters from reset, responses consumed immediately
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = op_a(i);
            req_b[32*i +: 32] = op_b(i);
        end
        rsp_rdy = 4'b1111;
        req_vld = 4'b1111;
        #1;
        for (int k = 0; k < 6; k++) begin
            exp_oh = (k < 4) ? (4'b0001 << k) : 4'b0000;
            chk("t2_grant", req_rdy, exp_oh);
            if (k >= 1 && k <= 4) begin
                chk("t2_arg_vld", add_arg_vld, 1);
                chk("t2_add_a", add_a, op_a(k - 1));
            end
            if (k >= 2) begin
                exp_oh = 4'b0001 << (k - 2);
                chk("t2_rsp_vld", rsp_vld, exp_oh);
                chk("t2_result", rsp_result[32*(k-2) +: 32], op_a(k - 2) + op_b(k - 2));
            end
            tick();
            if (k < 4) req_vld[k] = 1'b0;
            #1;
        end
        tick(); tick(); tick();

        // backpressure on requester 1
        req_vld = 4'b0011;
        rsp_rdy = 4'b1101;
        #1;
        for (int j = 0; j < 9; j++) begin
            chk("t3_grant", req_rdy, bp_rdy[j]);
            if (j >= 3) chk("t3_rsp1_held", rsp_vld[1], 1);
            tick();
        end
        req_vld = 4'b0010;
        rsp_rdy = 4'b1111;
        #1;
        chk("t3_rsp1_still", rsp_vld[1], 1);
        tick();
        chk("t3_rsp1_clear", rsp_vld[1], 0);
        chk("t3_no_regrant_yet", req_rdy, 0);
        tick();
        chk("t3_regrant", req_rdy, 4'b0010);
        tick();
        req_vld = '0;
        tick(); tick(); tick(); tick();

        // tag FIFO full with the adder stalled
        stall = 1'b1;
        req_vld = 4'b1111;
        #1;
        chk("t4_grant2", req_rdy, 4'b0100);
        tick();
        chk("t4_grant3", req_rdy, 4'b1000);
        tick();
        chk("t4_full_block", req_rdy, 0);
        chk("t4_arg_vld", add_arg_vld, 1);
        tick();
        chk("t4_full_block2", req_rdy, 0);
        chk("t4_arg_idle", add_arg_vld, 0);
        chk("t4_no_rsp", rsp_vld, 0);
        stall = 1'b0;
        tick();
        chk("t4_resume", req_rdy, 4'b0001);
        chk("t4_rsp2", rsp_vld, 4'b0100);
        chk("t4_result2", rsp_result[64 +: 32], op_a(2) + op_b(2));
        tick();
        chk("t4_grant1", req_rdy, 4'b0010);
        chk("t4_rsp3", rsp_vld, 4'b1000);
        chk("t4_result3", rsp_result[96 +: 32], op_a(3) + op_b(3));
        tick();
        req_vld = '0;
        tick(); tick(); tick(); tick(); tick();

        // NaN operand on requester 2
        req_a[64 +: 32] = 32'h7FC0_0000;
        req_b[64 +: 32] = 32'h3F80_0000;
        req_vld = 4'b0100;
        #1;
        chk("t5_grant", req_rdy, 4'b0100);
        tick();
        req_vld = '0;
        tick();
        chk("t5_rsp_vld", rsp_vld, 4'b0100);
        chk("t5_state", rsp_state[4 +: 2], ST_NAN);
        chk("t5_result", rsp_result[64 +: 32], 32'h7FC0_0000);
        tick(); tick(); tick(); tick();

        // spurious result with nothing in flight
        inject = 1'b1;
        tick();
        chk("t6_err_set", err, 1);
        chk("t6_no_rsp", rsp_vld, 0);
        inject = 1'b0;
        tick();
        chk("t6_err_sticky", err, 1);
        chk("t6_no_rsp2", rsp_vld, 0);
        rst = 1'b1;
        #1;
        chk("t6_err_cleared", err, 0);
        tick();
        rst = 1'b0;

        // reset mid-flight, then a stale result arrives
        stall = 1'b1;
        req_vld = 4'b0001;
        tick();
        req_vld = 4'b0010;
        tick();
        chk("t6_pre_rst_add_a", add_a, op_a(1));
        rst = 1'b1;
        #1;
        chk("t6_async_add_a", add_a, 0);
        chk("t6_async_add_b", add_b, 0);
        chk("t6_async_arg_vld", add_arg_vld, 0);
        chk("t6_async_req_rdy", req_rdy, 0);
        chk("t6_async_rsp_vld", rsp_vld, 0);
        chk("t6_async_err", err, 0);
        tick();
        rst = 1'b0;
        stall = 1'b0;
        req_vld = '0;
        tick();
        chk("t6_stale_err", err, 1);
        chk("t6_stale_no_rsp", rsp_vld, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
